// File: rtl/reverse_rotate_pipe.sv
// reverse_rotate_pipe
//   Two-stage registered datapath. It optionally bit-reverses a WIDTH-bit
//   operand, then rotates the result left or right by a per-transaction amount.
//
//   S1 registers the (optionally reversed) data, the effective right-rotate
//   amount and a valid flag. S2 registers the rotated result.
//
//   Optional build macro: RRP_ZERO_FLAG_EN. When it is defined, the block adds
//   out_zero, a flag registered in S2 that is high when the S2 data is all
//   zeros.
//
// Handshake (both sides):
//   A transfer happens on a rising clk edge where valid and ready are both
//   high. The producer must hold valid and payload stable while ready is low.
//   out_ready may feed in_ready combinationally.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous, active-low reset
//   in_valid   upstream offers a transaction
//   in_ready   block accepts the transaction this cycle
//   in_data    operand (WIDTH bits)
//   in_rev     1 = reverse the bit order before rotating
//   in_dir     0 = rotate right, 1 = rotate left
//   in_amt     rotate amount, 0..WIDTH-1 (SHW bits)
//   out_valid  result available
//   out_ready  downstream accepts the result
//   out_data   result (WIDTH bits)
//   out_zero   (RRP_ZERO_FLAG_EN only) S2 data is all zeros
module reverse_rotate_pipe #(
  parameter  int WIDTH = 16,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_rev,
  input  logic             in_dir,
  input  logic [SHW-1:0]   in_amt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef RRP_ZERO_FLAG_EN
  ,
  output logic             out_zero
`endif
);

  logic             s1_valid;
  logic [WIDTH-1:0] s1_data;
  logic [SHW-1:0]   s1_amt;
  logic             s2_valid;
  logic [WIDTH-1:0] s2_data;

  logic             s2_load;
  logic             in_fire;
  logic [WIDTH-1:0] rev_data;
  logic [SHW-1:0]   eff_amt;
  logic [2*WIDTH-1:0] dbl_shift;
  logic [WIDTH-1:0] rot_data;

  // S2 can take new contents when it is empty or its word leaves this edge.
  // S1 drains into S2 under the same condition.
  assign s2_load  = !s2_valid || out_ready;
  assign in_ready = !s1_valid || s2_load;
  assign in_fire  = in_valid && in_ready;

  always_comb begin
    rev_data = in_data;
    if (in_rev) begin
      for (int i = 0; i < WIDTH; i++) begin
        rev_data[i] = in_data[WIDTH-1-i];
      end
    end
  end

  // A left rotate by n equals a right rotate by (WIDTH - n) mod WIDTH.
  // WIDTH is a power of two, so an SHW-bit negation gives the modulo for free.
  assign eff_amt = in_dir ? (SHW'(0) - in_amt) : in_amt;

  // Rotate right: shift a doubled copy of the word and keep the low half.
  assign dbl_shift = {s1_data, s1_data} >> s1_amt;
  assign rot_data  = dbl_shift[WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_amt   <= '0;
    end else if (in_fire) begin
      s1_valid <= 1'b1;
      s1_data  <= rev_data;
      s1_amt   <= eff_amt;
    end else if (s2_load) begin
      s1_valid <= 1'b0;
    end
  end

  // S2 data is written only when a real word arrives. When the pipe
  // empties, the last result stays on out_data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_data  <= '0;
    end else if (s2_load) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_data <= rot_data;
      end
    end
  end

`ifdef RRP_ZERO_FLAG_EN
  logic s2_zero;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_zero <= 1'b0;
    end else if (s2_load && s1_valid) begin
      s2_zero <= (rot_data == '0);
    end
  end

  assign out_zero = s2_zero;
`endif

  assign out_valid = s2_valid;
  assign out_data  = s2_data;

endmodule

// File: tb/tb_reverse_rotate_pipe.sv
// Self-checking bench for reverse_rotate_pipe (WIDTH=16). Randomized and
// directed stimulus is scored against a behavioural model and an
// expected-result queue.
module tb_reverse_rotate_pipe;

  localparam int W = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          in_rev;
  logic          in_dir;
  logic [3:0]    in_amt;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
`ifdef RRP_ZERO_FLAG_EN
  logic          out_zero;
`endif

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] last_exp = '0;

  reverse_rotate_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_rev    (in_rev),
    .in_dir    (in_dir),
    .in_amt    (in_amt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef RRP_ZERO_FLAG_EN
    ,
    .out_zero  (out_zero)
`endif
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Reverse by reading the word's bits from the top down, then rotate with
  // integer shifts on a 32-bit value.
  function automatic logic [W-1:0] ref_model(input logic [W-1:0] d, input logic rev,
                                             input logic dir, input int amt);
    int x;
    int lamt;
    int r;
    x = 0;
    for (int i = 0; i < W; i++) begin
      if (rev) x = x * 2 + int'(d[i]);
      else     x = x * 2 + int'(d[W-1-i]);
    end
    lamt = dir ? amt : ((W - amt) % W);
    r = ((x << lamt) | (x >> (W - lamt))) & 32'hFFFF;
    return r[W-1:0];
  endfunction

  // ---------------- scoreboard ----------------
  // Inputs change just after posedge; at negedge they hold their pre-edge
  // values, so the transfers seen here are the ones taken at the next edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL sb_unexpected_output: got %h, none expected", out_data);
        end else begin
          last_exp = exp_q.pop_front();
          if (out_data !== last_exp) begin
            failures++;
            $display("FAIL sb_data: got %h expected %h", out_data, last_exp);
          end
        end
      end
      if (in_valid && in_ready)
        exp_q.push_back(ref_model(in_data, in_rev, in_dir, int'(in_amt)));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle_inputs();
    in_valid = 1'b0;
    in_data  = '0;
    in_rev   = 1'b0;
    in_dir   = 1'b0;
    in_amt   = '0;
  endtask

  task automatic rand_payload();
    in_data = W'($urandom_range(0, 65535));
    in_rev  = 1'($urandom_range(0, 1));
    in_dir  = 1'($urandom_range(0, 1));
    in_amt  = 4'($urandom_range(0, 15));
  endtask

  task automatic drain(input string name);
    int n;
    @(posedge clk) #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk) #1;
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_drain: %0d results missing", name, exp_q.size());
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== last_exp) begin
      failures++;
      $display("FAIL %s_idle_hold: valid=%b data=%h expected valid=0 data=%h",
               name, out_valid, out_data, last_exp);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    idle_inputs();
    out_ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk) #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_state: valid=%b data=%h in_ready=%b expected 0/0000/1",
               out_valid, out_data, in_ready);
    end
`ifdef RRP_ZERO_FLAG_EN
    checks++;
    if (out_zero !== 1'b0) begin
      failures++;
      $display("FAIL reset_zero_flag: got %b expected 0", out_zero);
    end
`endif
  endtask

  task automatic test_directed();
    logic [W-1:0] td [7] = '{16'h0001, 16'h1234, 16'h1234, 16'h1234, 16'h1234, 16'h0001, 16'h00F0};
    logic         tr [7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic         tdr[7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    logic [3:0]   ta [7] = '{4'd0, 4'd4, 4'd4, 4'd0, 4'd0, 4'd1, 4'd15};
    logic [W-1:0] te [7] = '{16'h8000, 16'h4123, 16'h2341, 16'h1234, 16'h1234, 16'h4000, 16'h0780};
    for (int i = 0; i < 7; i++) begin
      @(posedge clk) #1;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = td[i];
      in_rev    = tr[i];
      in_dir    = tdr[i];
      in_amt    = ta[i];
      @(posedge clk) #1;
      in_valid = 1'b0;
      @(posedge clk) #1;
      checks++;
      if (out_valid !== 1'b1 || out_data !== te[i]) begin
        failures++;
        $display("FAIL directed_%0d: valid=%b data=%h expected valid=1 data=%h",
                 i, out_valid, out_data, te[i]);
      end
    end
    drain("directed");
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] exp [8];
    for (int c = 0; c <= 10; c++) begin
      @(posedge clk) #1;
      out_ready = 1'b1;
      if (c >= 2 && c <= 9) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== exp[c-2]) begin
          failures++;
          $display("FAIL b2b_word%0d: valid=%b data=%h expected valid=1 data=%h",
                   c - 2, out_valid, out_data, exp[c-2]);
        end
      end else if (c == 10) begin
        checks++;
        if (out_valid !== 1'b0) begin
          failures++;
          $display("FAIL b2b_tail: valid=%b expected 0", out_valid);
        end
      end
      if (c < 8) begin
        in_valid = 1'b1;
        rand_payload();
        exp[c] = ref_model(in_data, in_rev, in_dir, int'(in_amt));
      end else begin
        in_valid = 1'b0;
      end
    end
    drain("b2b");
  endtask

  task automatic test_stall();
    int accepted;
    logic took;
    logic [W-1:0] first_exp;
    logic [W-1:0] held;
    @(posedge clk) #1;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    rand_payload();
    first_exp = ref_model(in_data, in_rev, in_dir, int'(in_amt));
    accepted = 0;
    held = '0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      took = in_ready;
      @(posedge clk) #1;
      if (took) begin
        accepted++;
        rand_payload();
      end
      if (c == 2) held = out_data;
    end
    checks++;
    if (accepted != 2) begin
      failures++;
      $display("FAIL stall_accept_count: got %0d expected 2", accepted);
    end
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== first_exp || out_data !== held) begin
      failures++;
      $display("FAIL stall_hold: in_ready=%b valid=%b data=%h expected 0/1/%h",
               in_ready, out_valid, out_data, first_exp);
    end
    // Releasing out_ready opens in_ready on the same cycle; the held word goes in.
    out_ready = 1'b1;
    @(posedge clk) #1;
    in_valid = 1'b0;
    drain("stall");
  endtask

  task automatic test_random();
    logic took;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      took = in_valid && in_ready;
      @(posedge clk) #1;
      if (!in_valid || took) begin
        in_valid = ($urandom_range(0, 3) != 0);
        rand_payload();
      end
      out_ready = ($urandom_range(0, 2) != 0);
    end
    drain("random");
  endtask

  task automatic test_reset_full();
    @(posedge clk) #1;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'hA5A5;
    in_rev    = 1'b0;
    in_dir    = 1'b0;
    in_amt    = 4'd3;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_full_setup: valid=%b in_ready=%b expected 1/0", out_valid, in_ready);
    end
    rst_n = 1'b0;
    @(posedge clk) #1;
    rst_n    = 1'b1;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_full: valid=%b data=%h in_ready=%b expected 0/0000/1",
               out_valid, out_data, in_ready);
    end
    last_exp = '0;
    drain("reset_full");
  endtask

`ifdef RRP_ZERO_FLAG_EN
  task automatic test_zero_flag();
    logic [W-1:0] zd [2] = '{16'h0000, 16'h0001};
    logic         ze [2] = '{1'b1, 1'b0};
    for (int i = 0; i < 2; i++) begin
      @(posedge clk) #1;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = zd[i];
      in_rev    = 1'($urandom_range(0, 1));
      in_dir    = 1'($urandom_range(0, 1));
      in_amt    = 4'($urandom_range(0, 15));
      @(posedge clk) #1;
      in_valid = 1'b0;
      @(posedge clk) #1;
      checks++;
      if (out_valid !== 1'b1 || out_zero !== ze[i]) begin
        failures++;
        $display("FAIL zero_flag_%0d: valid=%b zero=%b expected 1/%b", i, out_valid, out_zero, ze[i]);
      end
    end
    drain("zero_flag");
  endtask
`endif

  // ---------------- sequence + report ----------------
  initial begin
    rst_n = 1'b0;
    idle_inputs();
    out_ready = 1'b0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_stall();
    test_random();
    test_reset_full();
`ifdef RRP_ZERO_FLAG_EN
    test_zero_flag();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reverse_rotate_pipe.md
Name: reverse_rotate_pipe

Overview:
Parametrised, pipelined successor to the 16-bit bit-reverse block. It optionally reverses the bit order of a WIDTH-bit word, then rotates the result left or right by a per-transaction amount. It is a two-stage registered datapath with valid/ready handshakes on both sides, and sits in the shifter datapath between the operand source and the result sink.

Parameters:
WIDTH, 16, data width in bits; must be a power of 2 and at least 2.
SHW, $clog2(WIDTH), width of the rotate-amount field; derived, not overridden.

Ports:
clk  in  1  rising-edge clock.
rst_n  in  1  synchronous, active-low reset.
in_valid  in  1  upstream offers a transaction.
in_ready  out  1  block accepts the transaction this cycle.
in_data  in  WIDTH  operand.
in_rev  in  1  1 = reverse the bit order before rotating (bit i moves to bit WIDTH-1-i).
in_dir  in  1  0 = rotate right, 1 = rotate left.
in_amt  in  SHW  rotate amount, 0..WIDTH-1.
out_valid  out  1  result is available.
out_ready  in  1  downstream accepts the result.
out_data  out  WIDTH  result.

Behaviour:
- Reset: one clk edge with rst_n=0 clears both stage-valid flags, so out_valid=0 and out_data=0. in_ready=1 in the cycle after reset is released. Reset is synchronous only; rst_n has no asynchronous path.
- A transfer occurs on a clk edge where valid and ready are both high. The input side fires on in_valid & in_ready; the output side fires on out_valid & out_ready.
- Stage 1 (S1) registers three things:
  - data: reversed if in_rev=1, otherwise passed through unchanged;
  - the effective right-rotate amount: in_amt if in_dir=0; (WIDTH - in_amt) mod WIDTH if in_dir=1;
  - the valid bit.
- Stage 2 (S2) registers the S1 data rotated right by the S1 amount. An amount of 0 leaves the data unchanged, and so does a left rotate by 0.
- Latency: 2 clk cycles from the input transfer to out_valid, with no stalls. Throughput is 1 transaction per cycle.
- Stall and advance rules:
  - S2 loads when S2 is empty or the output fires.
  - S1 advances into S2 under the same condition.
  - in_ready = !S1_valid | S2_load.
  - The combinational path from out_ready to in_ready is permitted.
- Ordering: results leave in acceptance order. No transaction is dropped or duplicated under any out_ready pattern.
- Full condition: both stages hold data and out_ready=0. Then in_ready=0, and out_data and out_valid stay stable until the output fires.
- Simultaneous events: with a full pipe, out_ready=1 and in_valid=1, the output fires, S1 moves to S2 and the new input enters S1 on the same edge.
- Empty condition: out_valid=0. The value of out_data is don't-care but holds its last value; it does not toggle.
- Input stability: the producer may not withdraw in_valid or change payload while in_ready=0. Behaviour is undefined if it does.
- Reset mid-operation: in-flight transactions are discarded and the block returns to the reset state on the same edge.
- The S1 and S2 registers are enabled only when they load. Idle cycles must not change stored data.

Optional Feature:
Macro: RRP_ZERO_FLAG_EN.
- Defined: adds output out_zero (1 bit). It is registered in S2 alongside out_data and equals 1 when the S2 data is all zeros. Its reset value is 0, and it follows the same stall and hold rules as out_data.
- Undefined: the port does not exist and no extra logic is generated. All other behaviour is identical in both builds.

Test Plan:
1. WIDTH=16; in_data=16'h0001, rev=1, dir=0, amt=0 -> after 2 cycles out_data=16'h8000, out_valid=1.
2. in_data=16'h1234, rev=0, dir=0, amt=4 -> 16'h4123; the same with dir=1 -> 16'h2341; amt=0 in either direction -> 16'h1234.
3. in_data=16'h0001, rev=1, dir=0, amt=1 -> 16'h4000. in_data=16'h00F0, rev=1, dir=1, amt=15 -> 16'h0780.
4. Back-to-back stream of 8 words, out_ready=1 -> 8 results on 8 consecutive cycles starting 2 cycles after the first accept, in order.
5. out_ready=0 for 5 cycles while in_valid=1 -> exactly 2 words accepted, then in_ready=0 with out_data stable. Releasing out_ready -> all words delivered in order, none lost.
6. rst_n=0 for one edge with both stages full -> out_valid=0 and out_data=0 next cycle, in_ready=1. With RRP_ZERO_FLAG_EN, input 16'h0000 -> out_zero=1, input 16'h0001 -> out_zero=0.
